data_ram_arbiter: RTL and testbench

- Shares the single-port 8x256 data RAM between two requesters: port 0 (core load/store unit) and port 1 (loader/DMA engine).
- Drives the RAM's MemRead/MemWrite/Address/DataSrc, arbitrates round-robin with optional bounded lock, and returns registered read data with a one-cycle valid pulse.
- Sits between the core datapath and the data RAM; the RAM itself is unchanged.

---
 rtl/data_ram_arbiter.sv | 136 +++++++++++++
 tb/tb_data_ram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-port round-robin arbiter with bounded lock for the single-port data RAM
// Grants are combinational so the RAM access happens in the grant cycle; read data returns registered one cycle later.

module data_ram_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_LOCK = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] DataSrc,
   input  logic [DATA_W-1:0] DataMemOut
);

   localparam logic [7:0] LP_MAX_LOCK = 8'(MAX_LOCK);

   logic              r_last_gnt;
   logic              r_lock_vld;
   logic              r_lock_port;
   logic [7:0]        r_lock_cnt;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_any;
   logic              w_sel;
   logic              w_we;
   logic              w_lock;
   logic              w_lock_hold;

   // Reset gates every grant so the RAM cannot be written at an edge while reset is held.
   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_lock_hold = r_lock_vld && (r_lock_cnt < LP_MAX_LOCK);
      if (RST_N) begin
         if (req0 && !req1) begin
            w_gnt0 = 1'b1;
         end else if (req1 && !req0) begin
            w_gnt1 = 1'b1;
         end else if (req0 && req1) begin
            if (w_lock_hold) begin
               w_gnt0 = !r_lock_port;
               w_gnt1 = r_lock_port;
            end else begin
               w_gnt0 = r_last_gnt;
               w_gnt1 = !r_last_gnt;
            end
         end
      end
   end

   assign w_any  = w_gnt0 | w_gnt1;
   assign w_sel  = w_gnt1;
   assign w_we   = w_sel ? we1 : we0;
   assign w_lock = w_sel ? lock1 : lock0;

   assign gnt0     = w_gnt0;
   assign gnt1     = w_gnt1;
   assign MemWrite = w_any & w_we;
   assign MemRead  = w_any & ~w_we;
   assign Address  = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
   assign DataSrc  = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid0 <= w_gnt0 & ~we0;
         r_rvalid1 <= w_gnt1 & ~we1;
         if (w_gnt0 && !we0) begin
            r_rdata0 <= DataMemOut;
         end
         if (w_gnt1 && !we1) begin
            r_rdata1 <= DataMemOut;
         end
      end
   end

   // Lock state only moves on a grant; idle cycles leave a burst owner in place.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_last_gnt  <= 1'b1;
         r_lock_vld  <= 1'b0;
         r_lock_port <= 1'b0;
         r_lock_cnt  <= 8'd0;
      end else if (w_any) begin
         r_last_gnt <= w_sel;
         if (w_lock) begin
            r_lock_vld  <= 1'b1;
            r_lock_port <= w_sel;
            if (r_lock_vld && (r_lock_port == w_sel)) begin
               if (r_lock_cnt < LP_MAX_LOCK) begin
                  r_lock_cnt <= r_lock_cnt + 8'd1;
               end
            end else begin
               r_lock_cnt <= 8'd1;
            end
         end else begin
            r_lock_vld <= 1'b0;
            r_lock_cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed bench for data_ram_arbiter with a behavioural 256x8 RAM
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle or 1ns after the edge.

module tb_data_ram_arbiter;

   logic       CLK;
   logic       RST_N;
   logic       req0, req1, we0, we1, lock0, lock1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic       MemRead, MemWrite;
   logic [7:0] Address, DataSrc, DataMemOut;

   logic [7:0] mem [256];
   logic       pre_we;
   logic [7:0] pre_addr, pre_data;

   int n_checks;
   int n_fail;

   data_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .DataSrc(DataSrc), .DataMemOut(DataMemOut)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) begin
      if (MemWrite) mem[Address] <= DataSrc;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end
   assign DataMemOut = mem[Address];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      RST_N = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      pre_we = 1'b1; pre_addr = 8'h01; pre_data = 8'h11;
      step();
      pre_addr = 8'h02; pre_data = 8'h22;
      step();
      pre_addr = 8'h30; pre_data = 8'h5A;
      step();
      pre_we = 1'b0;

      // Reset: requests present, everything gated
      req0 = 1; req1 = 1; we0 = 1;
      mid();
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_memwrite", MemWrite, 0);
      check("rst_memread", MemRead, 0);
      check("rst_rvalid0", rvalid0, 0);
      check("rst_rvalid1", rvalid1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      step();

      // Both reading: 0,1,0,1
      RST_N = 1'b1;
      we0 = 0; addr0 = 8'h01; addr1 = 8'h02;
      for (int i = 0; i < 4; i++) begin
         mid();
         check("rr_gnt0", gnt0, (i % 2 == 0));
         check("rr_gnt1", gnt1, (i % 2 == 1));
         check("rr_addr", Address, (i % 2 == 0) ? 8'h01 : 8'h02);
         step();
         check("rr_rvalid0", rvalid0, (i % 2 == 0));
         check("rr_rvalid1", rvalid1, (i % 2 == 1));
         if (i % 2 == 0) check("rr_rdata0", rdata0, 8'h11);
         else            check("rr_rdata1", rdata1, 8'h22);
      end
      req0 = 0; req1 = 0;

      // Port 0 write A5 @10 then read it back
      req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
      mid();
      check("wr_gnt0", gnt0, 1);
      check("wr_memwrite", MemWrite, 1);
      check("wr_address", Address, 8'h10);
      check("wr_datasrc", DataSrc, 8'hA5);
      step();
      check("wr_mem", mem[8'h10], 8'hA5);
      check("wr_no_rvalid", rvalid0, 0);
      we0 = 0;
      mid();
      check("rd_gnt0", gnt0, 1);
      check("rd_memread", MemRead, 1);
      step();
      check("rd_rvalid0", rvalid0, 1);
      check("rd_rdata0", rdata0, 8'hA5);
      req0 = 0;
      mid();
      check("idle_gnt0", gnt0, 0);
      check("idle_memread", MemRead, 0);
      check("idle_address", Address, 0);
      step();
      check("rd_pulse_end", rvalid0, 0);
      check("rd_rdata_hold", rdata0, 8'hA5);

      // Port 1 lock burst, MAX_LOCK=4: 1,1,1,1,0 then lock released: 1,0
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; lock1 = 1; addr0 = 8'h01; addr1 = 8'h02;
      for (int i = 0; i < 5; i++) begin
         mid();
         check("lock_gnt1", gnt1, (i < 4));
         check("lock_gnt0", gnt0, (i == 4));
         step();
      end
      lock1 = 0;
      for (int i = 0; i < 2; i++) begin
         mid();
         check("unlock_gnt1", gnt1, (i == 0));
         check("unlock_gnt0", gnt0, (i == 1));
         step();
      end
      req0 = 0; req1 = 0;

      // Port 1 writes 3C @20, port 0 reads @20 the next cycle
      req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
      mid();
      check("hz_gnt1", gnt1, 1);
      check("hz_memwrite", MemWrite, 1);
      step();
      check("hz_no_rvalid1", rvalid1, 0);
      req1 = 0; we1 = 0;
      req0 = 1; we0 = 0; addr0 = 8'h20;
      mid();
      check("hz_gnt0", gnt0, 1);
      step();
      check("hz_rvalid0", rvalid0, 1);
      check("hz_rdata0", rdata0, 8'h3C);
      check("hz_rvalid1", rvalid1, 0);
      req0 = 0;

      // Port 0 loses one contest and withdraws
      req0 = 1; req1 = 1; addr0 = 8'h10; addr1 = 8'h01;
      mid();
      check("cx_gnt1", gnt1, 1);
      check("cx_gnt0", gnt0, 0);
      step();
      check("cx_rvalid1", rvalid1, 1);
      check("cx_rdata1", rdata1, 8'h11);
      check("cx_rvalid0_a", rvalid0, 0);
      req0 = 0; req1 = 0;
      mid();
      check("cx_gnt0_after", gnt0, 0);
      step();
      check("cx_rvalid0_b", rvalid0, 0);
      check("cx_rdata0", rdata0, 8'h3C);

      // Reset asserted mid-cycle during a port 0 write grant
      req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 8'h77;
      mid();
      check("mr_memwrite_pre", MemWrite, 1);
      #1;
      RST_N = 1'b0;
      #1;
      check("mr_memwrite", MemWrite, 0);
      check("mr_gnt0", gnt0, 0);
      check("mr_rdata0", rdata0, 0);
      check("mr_rdata1", rdata1, 0);
      check("mr_rvalid0", rvalid0, 0);
      step();
      check("mr_mem", mem[8'h30], 8'h5A);
      check("mr_rvalid0_edge", rvalid0, 0);
      RST_N = 1'b1;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h10; addr1 = 8'h01;
      mid();
      check("mr_post_gnt0", gnt0, 1);
      check("mr_post_gnt1", gnt1, 0);
      step();
      check("mr_post_rvalid0", rvalid0, 1);
      check("mr_post_rdata0", rdata0, 8'hA5);
      req0 = 0; req1 = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
